// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch-path types: fetch FSM states, machine word and the
// sequential PC increment.
package legv8_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/pc_step_adder.sv
// Sequential next-PC adder: pc + PC_STEP, wrapping modulo 2^32.
module pc_step_adder
  import legv8_pkg::*;
(
  input  word_t pc_i,
  output word_t pc_next_o
);

  assign pc_next_o = pc_i + PC_STEP;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, instruction-fetch FSM and single-entry instruction holding
// register handing one fetched word at a time to decode.
module pc_fetch_sequencer
  import legv8_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        req_addr_q, req_addr_d;
  word_t        instr_q, instr_d;
  word_t        instr_pc_q, instr_pc_d;
  logic         imem_req_q, imem_req_d;
  logic         instr_valid_q, instr_valid_d;
  logic         misalign_q, misalign_d;

  word_t        pc_plus4_s;
  word_t        target_s;
  logic         transfer_s;

  pc_step_adder u_pc_step_adder (
    .pc_i      (pc_q),
    .pc_next_o (pc_plus4_s)
  );

  assign target_s   = {branch_target[31:2], 2'b00};
  assign transfer_s = instr_valid_q & instr_ready & ~stall;

  // Next-state logic; req_addr only moves when a new request starts, so the
  // memory sees a stable address through DRAIN even after a redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    imem_req_d    = 1'b0;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = branch_taken & (branch_target[1:0] != 2'b00);

    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
        if (branch_taken) begin
          pc_d       = target_s;
          req_addr_d = target_s;
        end else begin
          req_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          pc_d       = target_s;
          imem_req_d = 1'b1;
          if (imem_ack) begin
            req_addr_d = target_s;
            state_d    = FETCH;
          end else begin
            state_d    = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d          = target_s;
          req_addr_d    = target_s;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FETCH;
        end else if (transfer_s) begin
          pc_d          = pc_plus4_s;
          req_addr_d    = pc_plus4_s;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        imem_req_d = 1'b1;
        if (branch_taken) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d       = BOOT;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      imem_req_q    <= imem_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = req_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed stimulus pushes expected
// fetch addresses and delivered instructions; a monitor pops and compares.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  logic mem_en;
  int   ack_delay;
  int   wait_cnt;

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .misalign      (misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hD503_201F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // Memory model: acks after ack_delay waiting cycles, rdata valid with ack.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_en && imem_req) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack   = 1'b0;
          wait_cnt   = wait_cnt + 1;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: fetch completions, decode transfers and request-address stability.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [31:0] e;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'h0000_0000;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req && prev_req && !prev_ack)
        chk("addr_stable", imem_addr, prev_addr);
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL fetch_addr: got unexpected fetch %h, expected none", imem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          chk("fetch_addr", imem_addr, e);
        end
      end
      if (instr_valid && instr_ready && !stall) begin
        if (exp_pc_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL transfer: got unexpected instr_pc %h, expected none", instr_pc);
        end else begin
          e = exp_pc_q.pop_front();
          chk("xfer_pc", instr_pc, e);
          chk("xfer_instr", instr, mem_word(e));
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  initial begin
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    stall         = 1'b0;
    instr_ready   = 1'b1;
    mem_en        = 1'b1;
    ack_delay     = 0;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_instr_pc", instr_pc, 32'h0000_0000);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    // Zero-wait streaming from RESET_PC
    exp_addr_q.push_back(32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0104);
    exp_addr_q.push_back(32'h0000_0108);
    exp_addr_q.push_back(32'h0000_010C);
    exp_pc_q.push_back(32'h0000_0100);
    exp_pc_q.push_back(32'h0000_0104);
    exp_pc_q.push_back(32'h0000_0108);
    rst_n = 1'b1;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_valid", {31'd0, instr_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    instr_ready = 1'b0;
    step();
    chk("hold_pc", instr_pc, 32'h0000_010C);

    // Stall in HOLD freezes the held instruction and blocks fetching
    instr_ready = 1'b1;
    stall       = 1'b1;
    exp_pc_q.push_back(32'h0000_010C);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", instr_pc, 32'h0000_010C);
      chk("stall_instr", instr, mem_word(32'h0000_010C));
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall     = 1'b0;
    ack_delay = 3;
    exp_addr_q.push_back(32'h0000_0110);
    exp_addr_q.push_back(32'h0000_2000);

    // Redirect in FETCH with a slow memory: DRAIN keeps the old address
    step();
    chk("after_stall_addr", imem_addr, 32'h0000_0110);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_2000;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_addr", imem_addr, 32'h0000_0110);
      chk("drain_misalign", {31'd0, misalign}, 32'd0);
      step();
    end
    chk("redir_addr", imem_addr, 32'h0000_2000);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    ack_delay   = 0;
    instr_ready = 1'b0;
    exp_pc_q.push_back(32'h0000_2000);
    step();
    chk("redir_hold_pc", instr_pc, 32'h0000_2000);

    // Misaligned redirect coinciding with an ack
    instr_ready = 1'b1;
    exp_addr_q.push_back(32'h0000_2004);
    exp_addr_q.push_back(32'h0000_3000);
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_3003;
    instr_ready   = 1'b0;
    step();
    branch_taken = 1'b0;
    chk("misalign_pulse", {31'd0, misalign}, 32'd1);
    chk("ack_redir_addr", imem_addr, 32'h0000_3000);
    chk("ack_redir_valid", {31'd0, instr_valid}, 32'd0);
    exp_pc_q.push_back(32'h0000_3000);
    step();
    chk("misalign_clear", {31'd0, misalign}, 32'd0);
    chk("ack_redir_pc", instr_pc, 32'h0000_3000);

    // Redirect in HOLD to the top word, then wrap on pc+4
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0000_0000);
    step();
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("top_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    instr_ready = 1'b0;
    step();
    chk("wrap_pc", instr_pc, 32'h0000_0000);

    // Asynchronous reset while draining
    instr_ready = 1'b1;
    ack_delay   = 5;
    step();
    chk("pre_drain_addr", imem_addr, 32'h0000_0004);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_5000;
    instr_ready   = 1'b0;
    step();
    branch_taken = 1'b0;
    chk("drain2_addr", imem_addr, 32'h0000_0004);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'h0000_0000);
    chk("arst_instr_pc", instr_pc, 32'h0000_0000);
    chk("arst_misalign", {31'd0, misalign}, 32'd0);
    ack_delay = 0;
    exp_addr_q.push_back(32'h0000_0100);
    exp_pc_q.push_back(32'h0000_0100);
    step();
    rst_n = 1'b1;
    step();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0000_0100);
    step();
    chk("restart_valid", {31'd0, instr_valid}, 32'd1);
    mem_en      = 1'b0;
    instr_ready = 1'b1;
    step();
    step();

    chk("addr_q_left", exp_addr_q.size(), 32'd0);
    chk("pc_q_left", exp_pc_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
